// File: rtl/cpu_run_controller.sv
// Bring-up sequencer between the board switches and the RISC-V core.
// Conditions the run/step switches, stretches the core reset, and gates the
// core clock-enable through a HOLD/HALTED/RUN/STEP state machine.

// One switch lane: 2-flop synchroniser followed by a level debouncer.
module cpu_run_sw_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK100MHZ,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise, then accept a new level only after it has been stable long enough
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module cpu_run_controller #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int STEP_CYCLES       = 1
) (
    input  logic        CLK100MHZ,
    input  logic        sw0,
    input  logic        sw1,
    input  logic        sw2,
    output logic        cpu_rst_n,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [31:0] cycle_count
);
    localparam int NUM_SW = 2;
    localparam int HW     = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int SW_W   = $clog2(STEP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_HALTED = 2'b01,
        S_RUN    = 2'b10,
        S_STEP   = 2'b11
    } state_t;

    // lane 0 = run switch, lane 1 = step button
    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] sw_db;
    logic              run_db;
    logic              step_db;
    logic              step_db_q;
    logic              step_req;

    state_t            state_q, state_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [SW_W-1:0]   step_cnt, step_n;
    logic              rst_n_n;
    logic              ce_n;

    assign sw_raw = {sw2, sw1};

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
        cpu_run_sw_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
            .CLK100MHZ (CLK100MHZ),
            .rst       (sw0),
            .raw       (sw_raw[gi]),
            .level     (sw_db[gi])
        );
    end

    assign run_db  = sw_db[0];
    assign step_db = sw_db[1];

    // Remember the previous debounced step level so a held button requests once
    always_ff @(posedge CLK100MHZ) begin
        if (sw0) step_db_q <= 1'b0;
        else     step_db_q <= step_db;
    end

    assign step_req = step_db & ~step_db_q;

    // Next-state and output decode; outputs follow the next state so they
    // change on the same edge as the state register
    always_comb begin
        state_n = state_q;
        hold_n  = hold_cnt;
        step_n  = step_cnt;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
                    state_n = S_HALTED;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            S_HALTED: begin
                // run beats a coincident step; the step is simply dropped
                if (run_db) begin
                    state_n = S_RUN;
                end else if (step_req) begin
                    state_n = S_STEP;
                    step_n  = '0;
                end
            end
            S_RUN: begin
                if (!run_db) state_n = S_HALTED;
            end
            S_STEP: begin
                if (step_cnt == SW_W'(STEP_CYCLES - 1)) state_n = S_HALTED;
                else                                    step_n  = step_cnt + 1'b1;
            end
            default: begin
                state_n = S_HOLD;
                hold_n  = '0;
            end
        endcase
        rst_n_n = (state_n != S_HOLD);
        ce_n    = (state_n == S_RUN) || (state_n == S_STEP);
    end

    // State, counters and registered core controls
    always_ff @(posedge CLK100MHZ) begin
        if (sw0) begin
            state_q   <= S_HOLD;
            hold_cnt  <= '0;
            step_cnt  <= '0;
            cpu_rst_n <= 1'b0;
            cpu_ce    <= 1'b0;
        end else begin
            state_q   <= state_n;
            hold_cnt  <= hold_n;
            step_cnt  <= step_n;
            cpu_rst_n <= rst_n_n;
            cpu_ce    <= ce_n;
        end
    end

    // Count cycles in which the core was enabled; wraps silently
    always_ff @(posedge CLK100MHZ) begin
        if (sw0)         cycle_count <= '0;
        else if (cpu_ce) cycle_count <= cycle_count + 32'd1;
    end

    assign state = state_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with short debounce/hold settings.
module tb_cpu_run_controller;
    logic        CLK100MHZ = 1'b0;
    logic        sw0, sw1, sw2;
    logic        cpu_rst_n, cpu_ce;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_run_controller #(
        .DEBOUNCE_CYCLES   (4),
        .RESET_HOLD_CYCLES (8),
        .STEP_CYCLES       (1)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .sw0         (sw0),
        .sw1         (sw1),
        .sw2         (sw2),
        .cpu_rst_n   (cpu_rst_n),
        .cpu_ce      (cpu_ce),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance n cycles; outputs are sampled at negedge
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sw0 = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
        cyc(3);
        // 1: reset state, then reset stretch
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_rstn",  {31'd0, cpu_rst_n}, 32'd0);
        check("rst_ce",    {31'd0, cpu_ce}, 32'd0);
        check("rst_count", cycle_count, 32'd0);
        sw0 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            check("hold_state", {30'd0, state}, 32'd0);
            check("hold_rstn",  {31'd0, cpu_rst_n}, 32'd0);
        end
        cyc(1);
        check("halt_state", {30'd0, state}, 32'd1);
        check("halt_rstn",  {31'd0, cpu_rst_n}, 32'd1);
        check("halt_ce",    {31'd0, cpu_ce}, 32'd0);
        check("halt_count", cycle_count, 32'd0);

        // 2: run for 20 cycles
        sw1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            check("run_lat_state", {30'd0, state}, 32'd1);
            check("run_lat_ce",    {31'd0, cpu_ce}, 32'd0);
        end
        cyc(1);
        check("run_state", {30'd0, state}, 32'd2);
        check("run_ce",    {31'd0, cpu_ce}, 32'd1);
        check("run_count0", cycle_count, 32'd0);
        cyc(13);
        check("run_count13", cycle_count, 32'd13);
        sw1 = 1'b0;
        for (int i = 21; i <= 26; i++) begin
            cyc(1);
            check("stop_lat_state", {30'd0, state}, 32'd2);
            check("stop_lat_ce",    {31'd0, cpu_ce}, 32'd1);
        end
        cyc(1);
        check("stop_state", {30'd0, state}, 32'd1);
        check("stop_ce",    {31'd0, cpu_ce}, 32'd0);
        check("stop_count", cycle_count, 32'd20);
        cyc(3);
        check("stop_count_hold", cycle_count, 32'd20);

        // 3: two single steps, button held 10 cycles each
        for (int p = 0; p < 2; p++) begin
            sw2 = 1'b1;
            for (int i = 1; i <= 6; i++) begin
                cyc(1);
                check("step_lat_state", {30'd0, state}, 32'd1);
                check("step_lat_ce",    {31'd0, cpu_ce}, 32'd0);
            end
            cyc(1);
            check("step_state", {30'd0, state}, 32'd3);
            check("step_ce",    {31'd0, cpu_ce}, 32'd1);
            check("step_rstn",  {31'd0, cpu_rst_n}, 32'd1);
            check("step_count_pre", cycle_count, 32'd20 + 32'(p));
            cyc(1);
            check("step_done_state", {30'd0, state}, 32'd1);
            check("step_done_ce",    {31'd0, cpu_ce}, 32'd0);
            check("step_count_post", cycle_count, 32'd21 + 32'(p));
            cyc(2);
            sw2 = 1'b0;
            for (int i = 11; i <= 22; i++) begin
                cyc(1);
                check("step_held_ce",    {31'd0, cpu_ce}, 32'd0);
                check("step_held_state", {30'd0, state}, 32'd1);
            end
        end
        check("step_count_total", cycle_count, 32'd22);

        // 4: glitches shorter than the debounce window do nothing
        sw1 = 1'b1; cyc(3); sw1 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            check("glitch_run_state", {30'd0, state}, 32'd1);
            check("glitch_run_ce",    {31'd0, cpu_ce}, 32'd0);
        end
        sw2 = 1'b1; cyc(2); sw2 = 1'b0; cyc(2); sw2 = 1'b1; cyc(2); sw2 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            check("bounce_step_state", {30'd0, state}, 32'd1);
            check("bounce_step_ce",    {31'd0, cpu_ce}, 32'd0);
        end
        check("glitch_count", cycle_count, 32'd22);

        // 5: reset in the middle of RUN, release with run still selected
        sw1 = 1'b1;
        cyc(7);
        check("rerun_state", {30'd0, state}, 32'd2);
        cyc(3);
        sw0 = 1'b1;
        cyc(1);
        check("abort_state", {30'd0, state}, 32'd0);
        check("abort_rstn",  {31'd0, cpu_rst_n}, 32'd0);
        check("abort_ce",    {31'd0, cpu_ce}, 32'd0);
        check("abort_count", cycle_count, 32'd0);
        sw0 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            check("rehold_state", {30'd0, state}, 32'd0);
            check("rehold_ce",    {31'd0, cpu_ce}, 32'd0);
        end
        cyc(1);
        check("rehalt_state", {30'd0, state}, 32'd1);
        check("rehalt_rstn",  {31'd0, cpu_rst_n}, 32'd1);
        check("rehalt_ce",    {31'd0, cpu_ce}, 32'd0);
        cyc(1);
        check("reacq_state", {30'd0, state}, 32'd2);
        check("reacq_ce",    {31'd0, cpu_ce}, 32'd1);
        check("reacq_count", cycle_count, 32'd0);

        // 6: counter wrap
        force dut.cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_count;
        cyc(1); check("wrap_ffffffff", cycle_count, 32'hFFFF_FFFF);
        cyc(1); check("wrap_0",        cycle_count, 32'h0000_0000);
        cyc(1); check("wrap_1",        cycle_count, 32'h0000_0001);

        // 6: run and step arriving together -> run only
        sw1 = 1'b0;
        cyc(7);
        check("pre_coinc_state", {30'd0, state}, 32'd1);
        cyc(2);
        sw1 = 1'b1; sw2 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            check("coinc_lat_state", {30'd0, state}, 32'd1);
        end
        cyc(1);
        check("coinc_state", {30'd0, state}, 32'd2);
        check("coinc_ce",    {31'd0, cpu_ce}, 32'd1);
        cyc(1);
        check("coinc_still_run", {30'd0, state}, 32'd2);
        sw1 = 1'b0; sw2 = 1'b0;
        for (int i = 2; i <= 7; i++) begin
            cyc(1);
            check("coinc_stop_lat", {30'd0, state}, 32'd2);
        end
        cyc(1);
        check("coinc_halt", {30'd0, state}, 32'd1);
        cyc(3);
        check("coinc_no_step", {30'd0, state}, 32'd1);
        check("coinc_no_step_ce", {31'd0, cpu_ce}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
